// File: rtl/game_pkg.sv
// Shared definitions for the board-game datapath: player widths, the turn
// sequencer state encoding and the default turn timeout.
package game_pkg;

  localparam int PLAYER_W         = 2;
  localparam int MAX_PLAYERS      = 4;
  localparam int TURN_TIMEOUT_DEF = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLIP,
    WAIT_MATCH,
    ADVANCE,
    CHECK,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/turn_timer.sv
// Saturating up-counter with synchronous clear and enable. The terminal
// value is a port, so one instance serves both turn timeout and win latency.
module turn_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Stops at the terminal value, so o_tc stays high until the next clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_term)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/turn_sequencer.sv
// Game-flow controller: owns the turn number, issues the advance strobe,
// samples the win checker and latches the winner until the next start.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS  = 4,
  parameter int TURN_TIMEOUT = TURN_TIMEOUT_DEF,
  parameter int WIN_LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                btn,
  input  logic                match_valid,
  input  logic                tile_match,
  input  logic                win,
  output logic [PLAYER_W-1:0] T,
  output logic                B,
  output logic                flip_req,
  output logic                pos_clr,
  output logic                game_over,
  output logic [PLAYER_W-1:0] winner
);

  localparam int TW0 = $clog2(TURN_TIMEOUT + 1);
  // Never narrower than 3 bits so the same counter can time WIN_LAT up to 7.
  localparam int TW  = (TW0 < 3) ? 3 : TW0;
  localparam int NP  = (NUM_PLAYERS > MAX_PLAYERS) ? MAX_PLAYERS : NUM_PLAYERS;
  localparam logic [PLAYER_W-1:0] LAST = PLAYER_W'(NP - 1);

  state_t              r_state;
  logic [PLAYER_W-1:0] r_T;
  logic [PLAYER_W-1:0] r_winner;
  logic                r_B;
  logic                r_flip_req;
  logic                r_pos_clr;
  logic                r_game_over;

  logic                w_count;
  logic                w_tc;
  logic                w_to;
  logic                w_leave;
  logic [TW-1:0]       w_term;

  assign w_count = (r_state == WAIT_FLIP) || (r_state == WAIT_MATCH) ||
                   (r_state == CHECK);
  assign w_term  = (r_state == CHECK) ? TW'(WIN_LAT) : TW'(TURN_TIMEOUT);
  assign w_to    = (TURN_TIMEOUT != 0) && w_tc;

  // Any exit from a counting state clears the timer, so each entry starts at 0.
  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      WAIT_FLIP:  w_leave = btn | w_to;
      WAIT_MATCH: w_leave = match_valid | w_to;
      CHECK:      w_leave = w_tc;
      default:    w_leave = 1'b0;
    endcase
  end

  turn_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (!w_count || w_leave),
    .i_en   (w_count),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_T         <= '0;
      r_winner    <= '0;
      r_B         <= 1'b0;
      r_flip_req  <= 1'b0;
      r_pos_clr   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_B        <= 1'b0;
      r_flip_req <= 1'b0;
      r_pos_clr  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_pos_clr   <= 1'b1;
            r_T         <= '0;
            r_game_over <= 1'b0;
            r_winner    <= '0;
            r_state     <= WAIT_FLIP;
          end
        end
        WAIT_FLIP: begin
          if (btn) begin
            r_flip_req <= 1'b1;
            r_state    <= WAIT_MATCH;
          end else if (w_to) begin
            r_state <= NEXT;
          end
        end
        WAIT_MATCH: begin
          if (match_valid) begin
            r_state <= tile_match ? ADVANCE : NEXT;
          end else if (w_to) begin
            r_state <= NEXT;
          end
        end
        ADVANCE: begin
          r_B     <= 1'b1;
          r_state <= CHECK;
        end
        CHECK: begin
          if (w_tc) begin
            if (win) begin
              r_winner    <= r_T;
              r_game_over <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= WAIT_FLIP;
            end
          end
        end
        NEXT: begin
          r_T     <= (r_T >= LAST) ? '0 : r_T + PLAYER_W'(1);
          r_state <= WAIT_FLIP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign T         = r_T;
  assign B         = r_B;
  assign flip_req  = r_flip_req;
  assign pos_clr   = r_pos_clr;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer (3 players, timeout 10, win latency 1):
// stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_turn_sequencer;

  localparam int NP = 3;
  localparam int TO = 10;
  localparam int WL = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, btn = 1'b0, match_valid = 1'b0, tile_match = 1'b0, win = 1'b0;
  logic [1:0] T, winner;
  logic       B, flip_req, pos_clr, game_over;

  turn_sequencer #(.NUM_PLAYERS(NP), .TURN_TIMEOUT(TO), .WIN_LAT(WL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn         (btn),
    .match_valid (match_valid),
    .tile_match  (tile_match),
    .win         (win),
    .T           (T),
    .B           (B),
    .flip_req    (flip_req),
    .pos_clr     (pos_clr),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         at;
    logic       pc;
    logic       fr;
    logic       b;
    logic       go;
    logic [1:0] t;
    logic [1:0] w;
  } ev_t;

  ev_t  expq[$];
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic [1:0] pT = '0;
  logic       pgo = 1'b0;

  function automatic void exp_ev(int at, logic pc, logic fr, logic b, logic go,
                                 logic [1:0] t, logic [1:0] w);
    ev_t e;
    e.at = at; e.pc = pc; e.fr = fr; e.b = b; e.go = go; e.t = t; e.w = w;
    expq.push_back(e);
  endfunction

  // Any visible output activity is an event and must match the queue head.
  always @(negedge clk) begin
    ev_t o, e;
    if (mon_en && (pos_clr || flip_req || B || (T != pT) || (game_over != pgo))) begin
      o.at = cyc; o.pc = pos_clr; o.fr = flip_req; o.b = B; o.go = game_over;
      o.t = T; o.w = winner;
      checks++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got pc=%b fr=%b B=%b go=%b T=%0d win=%0d required none",
                 cyc, o.pc, o.fr, o.b, o.go, o.t, o.w);
      end else begin
        e = expq.pop_front();
        if (e !== o) begin
          fails++;
          $display("FAIL event got cyc=%0d pc=%b fr=%b B=%b go=%b T=%0d win=%0d required cyc=%0d pc=%b fr=%b B=%b go=%b T=%0d win=%0d",
                   o.at, o.pc, o.fr, o.b, o.go, o.t, o.w, e.at, e.pc, e.fr, e.b, e.go, e.t, e.w);
        end
      end
    end
    pT  = T;
    pgo = game_over;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic clr_in();
    start = 0; btn = 0; match_valid = 0; tile_match = 0; win = 0;
  endtask

  // Drops the previous pulse at the next negedge, then drives the new one at
  // the first negedge with cyc >= c. Inputs are sampled at posedge dc+1.
  task automatic step_at(input int c, input logic s, input logic b, input logic mv,
                         input logic tm, input logic wn, output int dc);
    @(negedge clk);
    clr_in();
    while (cyc < c) @(negedge clk);
    start = s; btn = b; match_valid = mv; tile_match = tm; win = wn;
    dc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1);
  end

  initial begin
    int d, d1, d2, p, p2, nxt;
    #12;
    chk("rst_T", int'(T), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_flip_req", int'(flip_req), 0);
    chk("rst_pos_clr", int'(pos_clr), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    @(negedge clk); rst = 1'b1;
    #1 mon_en = 1'b1;

    // IDLE ignores btn and win; start+btn together takes start only.
    step_at(0, 0, 1, 0, 0, 1, d);
    step_at(0, 1, 1, 0, 0, 0, d);
    exp_ev(d + 1, 1, 0, 0, 0, 2'd0, 2'd0);
    // WAIT_FLIP ignores match_valid and start.
    step_at(0, 0, 0, 1, 1, 0, d);
    step_at(0, 1, 0, 0, 0, 0, d);
    nxt = 0;

    // Three misses: T 0 -> 1 -> 2 -> 0, no B.
    for (int t = 0; t < 3; t++) begin
      step_at(nxt, 0, 1, 0, 0, 0, d1);
      exp_ev(d1 + 1, 0, 1, 0, 0, 2'(t), 2'd0);
      step_at(d1 + 1, 0, 0, 1, 0, 0, d2);
      exp_ev(d2 + 2, 0, 0, 0, 0, 2'((t + 1) % NP), 2'd0);
      nxt = d2 + 2;
    end

    // Hit on player 0; win high before the sample cycle must be ignored.
    step_at(nxt, 0, 1, 0, 0, 1, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd0, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 1, 0, d2);
    exp_ev(d2 + 2, 0, 0, 1, 0, 2'd0, 2'd0);
    step_at(d2 + 2, 0, 0, 0, 0, 1, d);
    p = d2 + 4;

    // Flip timeout passes the turn; then btn coincident with timeout wins.
    exp_ev(p + 12, 0, 0, 0, 0, 2'd1, 2'd0);
    p2 = p + 12;
    step_at(p2 + 10, 0, 1, 0, 0, 0, d);
    exp_ev(d + 1, 0, 1, 0, 0, 2'd1, 2'd0);
    // match_valid coincident with the match timeout wins (hit keeps T=1).
    step_at(d + 11, 0, 0, 1, 1, 0, d2);
    exp_ev(d2 + 2, 0, 0, 1, 0, 2'd1, 2'd0);
    nxt = d2 + 4;

    // Miss: T 1 -> 2.
    step_at(nxt, 0, 1, 0, 0, 0, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd1, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 0, 0, d2);
    exp_ev(d2 + 2, 0, 0, 0, 0, 2'd2, 2'd0);
    nxt = d2 + 2;

    // Player 2 hits and wins at the sample cycle.
    step_at(nxt, 0, 1, 0, 0, 0, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd2, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 1, 0, d2);
    exp_ev(d2 + 2, 0, 0, 1, 0, 2'd2, 2'd0);
    step_at(d2 + 3, 0, 0, 0, 0, 1, d);
    exp_ev(d2 + 4, 0, 0, 0, 1, 2'd2, 2'd2);

    // DONE ignores btn, match_valid and win; start restarts.
    step_at(d2 + 5, 0, 1, 0, 0, 1, d);
    step_at(0, 0, 0, 1, 1, 0, d);
    step_at(0, 0, 1, 0, 0, 0, d);
    step_at(0, 1, 0, 0, 0, 0, d);
    exp_ev(d + 1, 1, 0, 0, 0, 2'd0, 2'd0);
    nxt = d + 1;

    // Miss to T=1, then hit and reset during the B/CHECK cycle.
    step_at(nxt, 0, 1, 0, 0, 0, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd0, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 0, 0, d2);
    exp_ev(d2 + 2, 0, 0, 0, 0, 2'd1, 2'd0);
    step_at(d2 + 2, 0, 1, 0, 0, 0, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd1, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 1, 0, d2);
    exp_ev(d2 + 2, 0, 0, 1, 0, 2'd1, 2'd0);
    @(negedge clk); clr_in();
    @(negedge clk);
    #2 mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_T", int'(T), 0);
    chk("async_rst_B", int'(B), 0);
    chk("async_rst_flip_req", int'(flip_req), 0);
    chk("async_rst_pos_clr", int'(pos_clr), 0);
    chk("async_rst_game_over", int'(game_over), 0);
    chk("async_rst_winner", int'(winner), 0);
    @(negedge clk); rst = 1'b1;
    #1 mon_en = 1'b1;

    // Normal play after reset.
    step_at(0, 1, 0, 0, 0, 0, d);
    exp_ev(d + 1, 1, 0, 0, 0, 2'd0, 2'd0);
    step_at(d + 1, 0, 1, 0, 0, 0, d1);
    exp_ev(d1 + 1, 0, 1, 0, 0, 2'd0, 2'd0);
    step_at(d1 + 1, 0, 0, 1, 0, 0, d2);
    exp_ev(d2 + 2, 0, 0, 0, 0, 2'd1, 2'd0);
    @(negedge clk); clr_in();
    repeat (4) @(negedge clk);

    chk("events_pending", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
